// File: rtl/mercury2_dac_pkg.sv
// mercury2_dac_pkg: shared widths and sequencer state encoding
package mercury2_dac_pkg;
  localparam int DAC_W = 10;
  localparam int ENTRY_W = DAC_W + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy and sticky overflow
module sync_fifo #(
  parameter int Width = 11,
  parameter int Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [Width-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [Width-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic overflow_q;
  logic push, pop;
  // A full queue drops the write even when a pop frees a slot this cycle
  assign push = wr_en_i && !full_o;
  assign pop = rd_en_i && !empty_o;
  assign full_o = count_q == CW'(Depth);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign overflow_o = overflow_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q <= count_q + CW'(push) - CW'(pop);
      overflow_q <= overflow_q | (wr_en_i & full_o);
    end
  end
  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/mercury2_dac_sequencer.sv
// mercury2_dac_sequencer: queues DAC samples and hands them one at a time to a busy/trigger DAC wrapper
module mercury2_dac_sequencer
  import mercury2_dac_pkg::*;
#(
  parameter int FifoDepth = 16,
  parameter int AckTimeout = 4
) (
  input  logic                         clk_50MHZ,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic                         wr_channel,
  input  logic [DAC_W-1:0]             wr_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FifoDepth):0]   count,
  output logic                         overflow,
  input  logic                         dac_busy,
  output logic                         dac_trigger,
  output logic                         dac_channel,
  output logic [DAC_W-1:0]             dac_din,
  output logic                         ack_error,
  output logic [15:0]                  samples_sent
);
  localparam int TW = $clog2(AckTimeout + 1);
  state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic ack_error_q, ack_error_d;
  logic [15:0] samples_sent_q, samples_sent_d;
  logic ch_q, ch_d;
  logic [DAC_W-1:0] din_q, din_d;
  logic pop;
  logic [ENTRY_W-1:0] head;
  sync_fifo #(.Width(ENTRY_W), .Depth(FifoDepth)) u_fifo (
    .clk(clk_50MHZ),
    .rst(reset),
    .wr_en_i(wr_en),
    .wr_data_i({wr_channel, wr_data}),
    .rd_en_i(pop),
    .rd_data_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count),
    .overflow_o(overflow)
  );
  assign dac_trigger = state_q == ISSUE;
  assign dac_channel = ch_q;
  assign dac_din = din_q;
  assign ack_error = ack_error_q;
  assign samples_sent = samples_sent_q;
  // Handshake sequencing: pop when the DAC is free, pulse, wait for busy to rise then fall
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ack_error_d = ack_error_q;
    samples_sent_d = samples_sent_q;
    ch_d = ch_q;
    din_d = din_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty && !dac_busy) begin
        pop = 1'b1;
        {ch_d, din_d} = head;
        state_d = ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: if (dac_busy) begin
        timer_d = '0;
        state_d = WAIT_DONE;
      end else if (timer_q == TW'(AckTimeout - 1)) begin
        timer_d = '0;
        ack_error_d = 1'b1;
        state_d = IDLE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
      WAIT_DONE: if (!dac_busy) begin
        samples_sent_d = samples_sent_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State, timeout counter, presented sample and conversion counter
  always_ff @(posedge clk_50MHZ) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      ack_error_q <= 1'b0;
      samples_sent_q <= '0;
      ch_q <= 1'b0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ack_error_q <= ack_error_d;
      samples_sent_q <= samples_sent_d;
      ch_q <= ch_d;
      din_q <= din_d;
    end
  end
endmodule

// File: tb/tb_mercury2_dac_sequencer.sv
// tb_mercury2_dac_sequencer: scoreboarded bench with a DAC wrapper model and random bursts
module tb_mercury2_dac_sequencer;
  logic clk = 1'b0;
  logic reset, wr_en, wr_channel, dac_busy;
  logic [9:0] wr_data;
  logic full, empty, overflow, dac_trigger, dac_channel, ack_error;
  logic [4:0] count;
  logic [9:0] dac_din;
  logic [15:0] samples_sent;
  int checks = 0, errors = 0;
  int cyc = 0, wcyc = 0, trig_cnt = 0, exp_sent = 0, t0 = 0, n = 0;
  int busy_mode = 2, hold_len = 1, hold_left = 0;
  bit trig_seen = 0;
  logic edge_busy = 1'b0;
  logic [10:0] exp_q[$];
  mercury2_dac_sequencer #(.FifoDepth(16), .AckTimeout(4)) dut (
    .clk_50MHZ(clk), .reset(reset), .wr_en(wr_en), .wr_channel(wr_channel), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .dac_busy(dac_busy),
    .dac_trigger(dac_trigger), .dac_channel(dac_channel), .dac_din(dac_din),
    .ack_error(ack_error), .samples_sent(samples_sent)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    edge_busy <= dac_busy;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  // DAC wrapper model: mode 0 raises busy the cycle after a trigger for hold_len cycles,
  // mode 1 holds busy high, mode 2 never acknowledges
  initial begin
    dac_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_mode == 1) begin
        dac_busy = 1'b1; hold_left = 0; trig_seen = 0;
      end else if (busy_mode == 2) begin
        dac_busy = 1'b0; hold_left = 0; trig_seen = 0;
      end else begin
        if (hold_left > 0) hold_left--;
        if (trig_seen) hold_left = hold_len;
        dac_busy = hold_left > 0;
        trig_seen = dac_trigger;
      end
    end
  end
  // Scoreboard: every trigger must present the oldest accepted sample, and only after an idle DAC
  always @(negedge clk) begin
    logic [10:0] e;
    if (dac_trigger) begin
      trig_cnt++;
      if (exp_q.size() == 0) check("trig_unexpected", 32'(trig_cnt), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("trig_sample", 32'({dac_channel, dac_din}), 32'(e));
      end
      check("trig_after_busy", 32'(edge_busy), 32'(0));
    end
  end
  task automatic wr(input logic ch, input logic [9:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_channel = ch; wr_data = d; wcyc = cyc;
    if (exp_q.size() < 16) exp_q.push_back({ch, d});
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask
  task automatic wait_trig(input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (dac_trigger) return;
    end
    check({tag, "_timeout"}, 32'(0), 32'(1));
  endtask
  task automatic drain(input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && samples_sent == exp_sent[15:0]) return;
    end
    check({tag, "_timeout"}, 32'(0), 32'(1));
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_sent = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_channel = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_full", 32'(full), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_count", 32'(count), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_ack_error", 32'(ack_error), 32'(0));
    check("rst_sent", 32'(samples_sent), 32'(0));
    check("rst_trigger", 32'(dac_trigger), 32'(0));
    check("rst_channel", 32'(dac_channel), 32'(0));
    check("rst_din", 32'(dac_din), 32'(0));
    // Single conversion latency and hold
    busy_mode = 0; hold_len = 100;
    wr(1'b0, 10'h155);
    wait_trig("lat_trig", 10);
    check("lat_cycle", 32'(cyc), 32'(wcyc + 2));
    check("lat_din", 32'(dac_din), 32'h155);
    check("lat_channel", 32'(dac_channel), 32'(0));
    repeat (50) @(negedge clk);
    check("lat_sent_busy", 32'(samples_sent), 32'(0));
    check("lat_din_hold", 32'(dac_din), 32'h155);
    exp_sent = 1;
    drain("lat_done", 300);
    check("lat_sent", 32'(samples_sent), 32'(1));
    // Fill to capacity and overflow
    do_reset();
    busy_mode = 1; dac_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(1'(i), 10'($urandom));
    @(negedge clk);
    check("full_flag", 32'(full), 32'(1));
    check("full_count", 32'(count), 32'(16));
    check("full_no_ovf", 32'(overflow), 32'(0));
    wr(1'b1, 10'h3FF);
    @(negedge clk);
    check("ovf_flag", 32'(overflow), 32'(1));
    check("ovf_full", 32'(full), 32'(1));
    check("ovf_count", 32'(count), 32'(16));
    t0 = trig_cnt;
    busy_mode = 0; hold_len = 2; dac_busy = 1'b0;
    exp_sent = 16;
    drain("ovf_drain", 600);
    check("ovf_sent", 32'(samples_sent), 32'(16));
    repeat (20) @(negedge clk);
    check("ovf_trig_total", 32'(trig_cnt - t0), 32'(16));
    check("ovf_sticky", 32'(overflow), 32'(1));
    check("ovf_empty", 32'(empty), 32'(1));
    // Acknowledge timeout
    do_reset();
    busy_mode = 2; dac_busy = 1'b0;
    wr(1'b1, 10'h2AA);
    wr(1'b0, 10'h0F0);
    wait_trig("ack_trig", 10);
    repeat (4) @(negedge clk);
    check("ack_err_early", 32'(ack_error), 32'(0));
    @(negedge clk);
    check("ack_err_set", 32'(ack_error), 32'(1));
    wait_trig("ack_next_trig", 10);
    repeat (10) @(negedge clk);
    check("ack_sent_none", 32'(samples_sent), 32'(0));
    busy_mode = 0; hold_len = 3;
    wr(1'b1, 10'h001);
    exp_sent = 1;
    drain("ack_recover", 200);
    check("ack_sent_one", 32'(samples_sent), 32'(1));
    check("ack_err_sticky", 32'(ack_error), 32'(1));
    // Reset while a trigger is being issued
    do_reset();
    busy_mode = 1; dac_busy = 1'b1;
    for (int i = 0; i < 3; i++) wr(1'(i), 10'($urandom));
    @(negedge clk);
    busy_mode = 0; hold_len = 3; dac_busy = 1'b0;
    wait_trig("rst_issue_trig", 10);
    reset = 1'b1;
    @(negedge clk);
    check("rst_issue_trigger", 32'(dac_trigger), 32'(0));
    check("rst_issue_count", 32'(count), 32'(0));
    check("rst_issue_empty", 32'(empty), 32'(1));
    reset = 1'b0;
    exp_q.delete();
    t0 = trig_cnt;
    repeat (30) @(negedge clk);
    check("rst_issue_no_trig", 32'(trig_cnt - t0), 32'(0));
    // Conversion counter wrap from a preloaded 65535
    do_reset();
    busy_mode = 0; hold_len = 1;
    @(negedge clk);
    force dut.samples_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.samples_sent_q;
    @(negedge clk);
    check("wrap_preload", 32'(samples_sent), 32'hFFFF);
    wr(1'b0, 10'($urandom));
    exp_sent = 65536;
    drain("wrap", 100);
    check("wrap_sent", 32'(samples_sent), 32'(0));
    // Simultaneous write and pop at occupancy 5
    do_reset();
    busy_mode = 1; dac_busy = 1'b1;
    for (int i = 0; i < 5; i++) wr(1'(i), 10'($urandom));
    @(negedge clk);
    check("wp_count_before", 32'(count), 32'(5));
    busy_mode = 0; hold_len = 2; dac_busy = 1'b0;
    wr_en = 1'b1; wr_channel = 1'b1; wr_data = 10'h1C3;
    exp_q.push_back({1'b1, 10'h1C3});
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(negedge clk);
    check("wp_count_after", 32'(count), 32'(5));
    exp_sent = 6;
    drain("wp", 300);
    check("wp_sent", 32'(samples_sent), 32'(6));
    // Random bursts against the scoreboard
    do_reset();
    for (int r = 0; r < 6; r++) begin
      busy_mode = 0; hold_len = $urandom_range(1, 6);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        wr(1'($urandom_range(0, 1)), 10'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      exp_sent += n;
      drain("rand", 600);
      check("rand_sent", 32'(samples_sent), 32'(exp_sent));
      check("rand_count", 32'(count), 32'(0));
      check("rand_empty", 32'(empty), 32'(1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
